simon_pipe_controller: RTL
==========================

# simon_pipe_controller

Iterative sequencer for the SIMON32/64 mixed-model datapath. It accepts one plaintext block and 64-bit key through a valid/ready handshake, then drives one `pipe_section` instance through 32/`mixed_size` passes. On each pass it generates the `mixed_size` round keys on the fly, and at the end it presents the ciphertext through a second valid/ready handshake. It sits between the host/stream interface and the `pipe_section` datapath and owns all state, control and key-schedule logic for the mixed model.

## Interface
- `mixed_size`, default 8: rounds per pass. Legal values are 1, 2, 4, 8, 16 and 32; any other value is a fatal elaboration error. Must match the instantiated `pipe_section`.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: plaintext/key offered.
- `in_ready` output 1: the block can accept; high only in IDLE.
- `plaintext` input 32: `[31:16]` = x, `[15:0]` = y.
- `key` input 64: `[63:48]` = k3, `[47:32]` = k2, `[31:16]` = k1, `[15:0]` = k0.
- `out_valid` output 1: ciphertext available.
- `out_ready` input 1: consumer accepts ciphertext.
- `ciphertext` output 32: same x/y packing as `plaintext`.
- `busy` output 1: high in RUN.
- `abort` input 1: present only with `SIMON_CTRL_ABORT_EN`.

## Operation
- FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE:** `in_ready`=1. When `in_valid` is high:
  - latch `plaintext` into `state_reg`;
  - latch k0..k3 into the key window;
  - clear `pass_cnt`;
  - go to RUN.
- **RUN:** each cycle:
  - `state_reg <= pipe_section(state_reg, round_keys)`;
  - the key window advances by `mixed_size` words;
  - `pass_cnt` increments.
  - After the pass where `pass_cnt` = N-1 (N = 32/`mixed_size`), go to DONE.
- **DONE:** `out_valid`=1 and `ciphertext` = `state_reg`. Hold both stable until `out_ready`=1, then go to IDLE.
- Key schedule is standard SIMON32/64 with m=4 and constant sequence z0.
  - Word i≥4: `k[i] = ~k[i-4] ^ t ^ (t>>>1) ^ z0[i-4] ^ 16'h0003`, where `t = (k[i-1]>>>3) ^ k[i-3]`. Rotates are 16-bit.
  - On pass p, round key j (j = 0..`mixed_size`-1) is `k[p*mixed_size + j]`, driven on `key_in[j]`.
  - Expansion is a combinational chain from the 4-word window producing `mixed_size`+4 words. The first `mixed_size` words go to the pipe; the last 4 are registered as the next window.
  - z0 index is at most 31, so there is no mod-62 wrap.
- `pass_cnt` width is `$clog2(N)`, minimum 1 bit.
- When `mixed_size`=32, RUN lasts exactly one cycle.
- `in_valid` outside IDLE is ignored; `in_ready`=0 there. No queuing.
- `out_ready` outside DONE is ignored.

## Timing
- Acceptance edge E0 (IDLE, `in_valid`=1).
- Passes occur on edges E1..EN; `busy`=1 between E0 and EN.
- `out_valid` rises after EN. For `mixed_size`=8, `out_valid` is high 4 cycles after acceptance.
- An output handshake at edge Ed returns to IDLE; `in_ready`=1 from Ed onward.
- Minimum issue interval is N+2 cycles.
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `ciphertext`=0, `state_reg`=0, key window=0, `pass_cnt`=0.
- Reset asserted mid-RUN or in DONE discards the operation and returns to reset values on the next edge; no partial output.
- `rst` has priority over every other input.

## Configuration
- **With `SIMON_CTRL_ABORT_EN` defined:**
  - an `abort` input port exists;
  - `abort`=1 in RUN or DONE returns to IDLE on the next edge with `out_valid`=0, and `state_reg` and the key window cleared;
  - `abort` in IDLE has priority over `in_valid`: no accept that cycle.
- **Without the macro:** the port is absent and operations always run to completion.

## Structure
- Shared package `simon_pkg` holds:
  - the `z0` constant (62-bit, bit 0 = z0[0]);
  - `ROUNDS`=32, `WORD_W`=16, `KEY_WORDS`=4;
  - the FSM state enum `ctrl_state_t`;
  - a `rol16`/`ror16` function pair.
- One natural sub-module, `key_expand_window`. Input: 4-word window plus base index `pass_cnt*mixed_size`. Outputs: `mixed_size` round keys and the next window. Purely combinational.
- The controller instantiates `pipe_section` and `key_expand_window`.

## Test plan
- **Reference vector:** `mixed_size`=8, `key`=64'h1918111009080100, `plaintext`=32'h65656877 → `out_valid` after 4 RUN edges with `ciphertext`=32'hc69be9bb.
- **Parameter sweep:** same vector for `mixed_size` ∈ {1, 2, 4, 16, 32} → same ciphertext, with N = 32, 16, 8, 2, 1 RUN cycles respectively.
- **Output backpressure:** hold `out_ready`=0 for 10 cycles in DONE → `out_valid` and `ciphertext` stable; `in_valid` with new data is not accepted (`in_ready`=0); accepted only after the `out_ready` handshake.
- **Reset mid-operation:** `rst`=1 at pass 2 → next cycle `in_ready`=1, `out_valid`=0, `busy`=0. A fresh run of the reference vector then gives 32'hc69be9bb.
- **Back-to-back:** two blocks with `out_ready` tied high → second acceptance exactly N+2 cycles after the first; both ciphertexts match a software model.
- **With `SIMON_CTRL_ABORT_EN`:**
  - `abort` in RUN → IDLE next cycle, no `out_valid`;
  - `abort` and `in_valid` together in IDLE → no accept.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared definitions for the SIMON32/64 mixed-model datapath.
// Contents: word/round/key-word sizes, the z0 round-constant sequence,
// the controller state enum and 16-bit rotate helpers.
package simon_pkg;

    localparam int unsigned ROUNDS    = 32;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned KEY_WORDS = 4;

    // Bit-reverse so that bit i of Z0 holds z0[i] (literal below is written z0[0] first).
    function automatic logic [61:0] rev62(input logic [61:0] v);
        logic [61:0] r;
        for (int i = 0; i < 62; i++) begin
            r[i] = v[61-i];
        end
        return r;
    endfunction

    localparam logic [61:0] Z0 =
        rev62(62'b11111010001001010110000111001101111101000100101011000011100110);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ctrl_state_t;

    // Rotate amount n must lie in 1..15.
    function automatic logic [WORD_W-1:0] rol16(input logic [WORD_W-1:0] v, input int unsigned n);
        return (v << n) | (v >> (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] ror16(input logic [WORD_W-1:0] v, input int unsigned n);
        return (v >> n) | (v << (WORD_W - n));
    endfunction

endpackage

// File: rtl/key_expand_window.sv
// On-the-fly SIMON32/64 key expansion for one pass (purely combinational).
// Ports: window      k[base..base+3], window[0] = k[base]
//        base        index of window[0] in the full key schedule
//        round_keys  k[base..base+mixed_size-1] for the current pass
//        next_window k[base+mixed_size..base+mixed_size+3]
module key_expand_window
    import simon_pkg::*;
#(
    parameter int unsigned mixed_size = 8
) (
    input  logic [KEY_WORDS-1:0][WORD_W-1:0]    window,
    input  logic [5:0]                          base,
    output logic [mixed_size-1:0][WORD_W-1:0]   round_keys,
    output logic [KEY_WORDS-1:0][WORD_W-1:0]    next_window
);

    logic [mixed_size+KEY_WORDS-1:0][WORD_W-1:0] seq;
    logic [WORD_W-1:0]                           tmp;
    logic [5:0]                                  zidx;

    // seq[i] = k[base+i]; z0 index never exceeds 31, so no mod-62 wrap is needed.
    always_comb begin
        seq  = '0;
        tmp  = '0;
        zidx = '0;
        seq[KEY_WORDS-1:0] = window;
        for (int i = KEY_WORDS; i < int'(mixed_size + KEY_WORDS); i++) begin
            tmp    = ror16(seq[i-1], 3) ^ seq[i-3];
            zidx   = base + 6'(i - KEY_WORDS);
            seq[i] = ~seq[i-4] ^ tmp ^ ror16(tmp, 1) ^ {15'd0, Z0[zidx]} ^ 16'h0003;
        end
    end

    assign round_keys  = seq[mixed_size-1:0];
    assign next_window = seq[mixed_size+KEY_WORDS-1:mixed_size];

endmodule

// File: rtl/pipe_section.sv
// Unrolled chain of mixed_size SIMON32 rounds (purely combinational).
// Ports: state_in  [31:16]=x, [15:0]=y
//        key_in    one 16-bit round key per round, key_in[0] used first
//        state_out state after all mixed_size rounds
module pipe_section
    import simon_pkg::*;
#(
    parameter int unsigned mixed_size = 8
) (
    input  logic [2*WORD_W-1:0]                 state_in,
    input  logic [mixed_size-1:0][WORD_W-1:0]   key_in,
    output logic [2*WORD_W-1:0]                 state_out
);

    logic [mixed_size:0][WORD_W-1:0] xs;
    logic [mixed_size:0][WORD_W-1:0] ys;

    // Round: x' = y ^ f(x) ^ k, y' = x, f(x) = (x<<<1 & x<<<8) ^ x<<<2
    always_comb begin
        xs = '0;
        ys = '0;
        xs[0] = state_in[2*WORD_W-1:WORD_W];
        ys[0] = state_in[WORD_W-1:0];
        for (int j = 0; j < int'(mixed_size); j++) begin
            xs[j+1] = ys[j] ^ (rol16(xs[j], 1) & rol16(xs[j], 8)) ^ rol16(xs[j], 2) ^ key_in[j];
            ys[j+1] = xs[j];
        end
    end

    assign state_out = {xs[mixed_size], ys[mixed_size]};

endmodule

// File: rtl/simon_pipe_controller.sv
// Iterative SIMON32/64 sequencer: accepts a block and key, runs one
// pipe_section over 32/mixed_size passes while expanding round keys on the
// fly, then offers the ciphertext until the consumer takes it.
// Ports: clk, rst (sync, active high)
//        in_valid/in_ready + plaintext[31:0] ({x,y}), key[63:0] ({k3,k2,k1,k0})
//        out_valid/out_ready + ciphertext[31:0] ({x,y})
//        busy   high while passes are running
//        abort  only when SIMON_CTRL_ABORT_EN is defined: drop the operation
module simon_pipe_controller
    import simon_pkg::*;
#(
    parameter int unsigned mixed_size = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*WORD_W-1:0]     plaintext,
    input  logic [KEY_WORDS*WORD_W-1:0] key,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*WORD_W-1:0]     ciphertext,
`ifdef SIMON_CTRL_ABORT_EN
    input  logic                    abort,
`endif
    output logic                    busy
);

    localparam int unsigned N_PASS = ROUNDS / mixed_size;
    localparam int unsigned PCW    = (N_PASS > 1) ? $clog2(N_PASS) : 1;

    if (!(mixed_size == 1 || mixed_size == 2 || mixed_size == 4 ||
          mixed_size == 8 || mixed_size == 16 || mixed_size == 32)) begin : g_bad_size
        $fatal(1, "simon_pipe_controller: mixed_size must be 1, 2, 4, 8, 16 or 32");
    end

    ctrl_state_t                            state_q, state_d;
    logic [2*WORD_W-1:0]                    state_reg, state_reg_d;
    logic [KEY_WORDS-1:0][WORD_W-1:0]       win_q, win_d;
    logic [PCW-1:0]                         pass_cnt, pass_cnt_d;
    logic [2*WORD_W-1:0]                    ciphertext_d;
    logic                                   in_ready_d, out_valid_d, busy_d;

    logic                                   abort_c;
    logic [5:0]                             base_c;
    logic [mixed_size-1:0][WORD_W-1:0]      round_keys_c;
    logic [KEY_WORDS-1:0][WORD_W-1:0]       next_win_c;
    logic [2*WORD_W-1:0]                    pipe_out_c;

`ifdef SIMON_CTRL_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    assign base_c = 6'(pass_cnt) * 6'(mixed_size);

    key_expand_window #(.mixed_size(mixed_size)) u_key_expand (
        .window      (win_q),
        .base        (base_c),
        .round_keys  (round_keys_c),
        .next_window (next_win_c)
    );

    pipe_section #(.mixed_size(mixed_size)) u_pipe (
        .state_in  (state_reg),
        .key_in    (round_keys_c),
        .state_out (pipe_out_c)
    );

    // Next-state and next-register values; handshake outputs follow the next state.
    always_comb begin
        state_d      = state_q;
        state_reg_d  = state_reg;
        win_d        = win_q;
        pass_cnt_d   = pass_cnt;
        ciphertext_d = ciphertext;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && !abort_c) begin
                    state_reg_d = plaintext;
                    win_d       = key;
                    pass_cnt_d  = '0;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_c) begin
                    state_reg_d = '0;
                    win_d       = '0;
                    state_d     = ST_IDLE;
                end else begin
                    state_reg_d = pipe_out_c;
                    win_d       = next_win_c;
                    pass_cnt_d  = pass_cnt + PCW'(1);
                    if (pass_cnt == PCW'(N_PASS - 1)) begin
                        ciphertext_d = pipe_out_c;
                        state_d      = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (abort_c) begin
                    state_reg_d = '0;
                    win_d       = '0;
                    state_d     = ST_IDLE;
                end else if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        busy_d      = (state_d == ST_RUN);
        out_valid_d = (state_d == ST_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            state_reg  <= '0;
            win_q      <= '0;
            pass_cnt   <= '0;
            ciphertext <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            state_reg  <= state_reg_d;
            win_q      <= win_d;
            pass_cnt   <= pass_cnt_d;
            ciphertext <= ciphertext_d;
            in_ready   <= in_ready_d;
            out_valid  <= out_valid_d;
            busy       <= busy_d;
        end
    end

endmodule
